// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
//
// Recovers the raster position of an incoming VGA stream from its
// active-low hsync/vsync, measures line and frame periods, and locks once the
// measured timing matches the parameter set.
//
// Ports:
//   clock         single clock, all logic on the rising edge
//   reset         synchronous, active-low reset
//   hsync, vsync  incoming active-low syncs, already in the clock domain
//   rx_col        recovered column counter (12 bits)
//   rx_row        recovered row counter (11 bits)
//   rx_visible    recovered visible-area flag (only while locked)
//   locked        timing locked to the parameter set
//   line_len      last measured hsync-fall-to-fall period, in cycles
//   frame_lines   last measured number of hsync falls per vsync period
//   timing_error  one-cycle pulse on a timing violation
//
// There are no handshakes: every input is sampled on every rising edge and
// every output is valid on every cycle.
module vga_sync_receiver #(
  parameter int HOR_FIELD    = 799,   // last visible column
  parameter int HOR_STR_SYNC = 855,   // first hsync-low column
  parameter int HOR_TOTAL    = 1042,  // last column of line
  parameter int VER_FIELD    = 599,   // last visible row
  parameter int VER_STR_SYNC = 636,   // first vsync-low row
  parameter int VER_TOTAL    = 665,   // last row of frame
  parameter int LOCK_LINES   = 4      // good lines required before frame check
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [11:0] rx_col,
  output logic [10:0] rx_row,
  output logic        rx_visible,
  output logic        locked,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        timing_error
);

  // The transmitter registers its syncs and we register them again, so the
  // first low sample is seen two columns after the transmitter's sync start.
  localparam logic [11:0] COL_LOAD = 12'(HOR_STR_SYNC + 2);
  localparam logic [11:0] COL_LAST = 12'(HOR_TOTAL);
  localparam logic [11:0] COL_VIS  = 12'(HOR_FIELD);
  localparam logic [10:0] ROW_LOAD = 11'(VER_STR_SYNC);
  localparam logic [10:0] ROW_LAST = 11'(VER_TOTAL);
  localparam logic [10:0] ROW_VIS  = 11'(VER_FIELD);

  // per_cnt holds (period - 1) at the hfall that closes a line.
  localparam logic [11:0] PER_GOOD    = 12'(HOR_TOTAL);
  // Timeout fires on the edge where per_cnt reaches two nominal lines.
  localparam logic [11:0] PER_TO_PRE  = 12'(2 * (HOR_TOTAL + 1) - 1);
  localparam logic [11:0] PER_MAX     = 12'hFFF;
  localparam logic [10:0] FRAME_GOOD  = 11'(VER_TOTAL + 1);
  localparam logic [10:0] LN_MAX      = 11'h7FF;

  localparam int GW = (LOCK_LINES < 1) ? 1 : $clog2(LOCK_LINES + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] good_cnt;

  logic        h_q;
  logic        v_q;
  logic        h_seen;     // at least one hfall since reset
  logic        v_seen;     // at least one vfall since reset
  logic [11:0] per_cnt;    // cycles since last hfall, saturating
  logic [10:0] ln_cnt;     // hfalls since last vfall, saturating

  logic hfall;
  logic vfall;
  logic line_ok;
  logic frame_ok;
  logic timeout;

  // ---------------------------------------------------------------------------
  // Edge detection and measurement qualifiers
  // ---------------------------------------------------------------------------
  always_comb begin
    hfall    = h_q & ~hsync;
    vfall    = v_q & ~vsync;
    // A period is only meaningful once a previous hfall has been seen.
    line_ok  = h_seen && (per_cnt == PER_GOOD);
    frame_ok = v_seen && (ln_cnt == FRAME_GOOD);
    // per_cnt saturates far above the timeout point, so it crosses this value
    // at most once between hfalls; that alone keeps the pulse single.
    timeout  = !hfall && (per_cnt == PER_TO_PRE);
  end

  assign rx_visible = locked && (rx_col <= COL_VIS) && (rx_row <= ROW_VIS);

  // ---------------------------------------------------------------------------
  // Raster recovery and period/frame measurement
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      h_q         <= 1'b0;
      v_q         <= 1'b0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      rx_col      <= '0;
      rx_row      <= '0;
      per_cnt     <= '0;
      ln_cnt      <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      h_q <= hsync;
      v_q <= vsync;

      // Column: resynchronise on hfall, otherwise free-run and wrap.
      if (hfall) begin
        rx_col <= COL_LOAD;
      end else if (rx_col >= COL_LAST) begin
        rx_col <= '0;
      end else begin
        rx_col <= rx_col + 12'd1;
      end

      // Row: resynchronise on vfall, otherwise advance on column wrap.
      if (vfall) begin
        rx_row <= ROW_LOAD;
      end else if (!hfall && (rx_col >= COL_LAST)) begin
        if (rx_row >= ROW_LAST) begin
          rx_row <= '0;
        end else begin
          rx_row <= rx_row + 11'd1;
        end
      end

      // Line period. The first hfall only starts the measurement.
      if (hfall) begin
        per_cnt <= '0;
        h_seen  <= 1'b1;
        if (h_seen) begin
          line_len <= (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 12'd1;
        end
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + 12'd1;
      end

      // Lines per frame. An hfall coinciding with vfall opens the new frame.
      if (vfall) begin
        ln_cnt <= hfall ? 11'd1 : 11'd0;
        v_seen <= 1'b1;
        if (v_seen) begin
          frame_lines <= ln_cnt;
        end
      end else if (hfall && (ln_cnt != LN_MAX)) begin
        ln_cnt <= ln_cnt + 11'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM; locked and timing_error are registered alongside the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= SEARCH;
      good_cnt     <= '0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      timing_error <= 1'b0;
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (timeout) begin
            timing_error <= 1'b1;
          end else if (vfall) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end

        MEASURE: begin
          if (timeout) begin
            timing_error <= 1'b1;
            state        <= SEARCH;
            good_cnt     <= '0;
            locked       <= 1'b0;
          end else if (vfall) begin
            if ((good_cnt >= GOOD_MAX) && frame_ok) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              good_cnt <= '0;
              locked   <= 1'b0;
            end
          end else if (hfall) begin
            // Mismatches here only reset the run of good lines; no error.
            if (line_ok) begin
              if (good_cnt != GOOD_MAX) begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          if (timeout || (hfall && !line_ok) || (vfall && !frame_ok)) begin
            timing_error <= 1'b1;
            state        <= SEARCH;
            good_cnt     <= '0;
            locked       <= 1'b0;
          end else begin
            locked <= 1'b1;
          end
        end

        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
//
// Directed bench for vga_sync_receiver using a reduced timing set so that
// whole frames fit in a short run (25-cycle lines, 15-line frames). A small
// transmitter model with registered syncs drives the DUT; expected values
// come from that model and from hand-computed constants.
module tb_vga_sync_receiver;

  localparam int HF   = 15;
  localparam int HSTR = 19;
  localparam int HT   = 24;
  localparam int VF   = 9;
  localparam int VSTR = 11;
  localparam int VT   = 14;
  localparam int LL   = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rx_col;
  logic [10:0] rx_row;
  logic        rx_visible;
  logic        locked;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic        timing_error;

  always #5 clock = ~clock;

  vga_sync_receiver #(
    .HOR_FIELD(HF), .HOR_STR_SYNC(HSTR), .HOR_TOTAL(HT),
    .VER_FIELD(VF), .VER_STR_SYNC(VSTR), .VER_TOTAL(VT),
    .LOCK_LINES(LL)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .rx_col(rx_col), .rx_row(rx_row), .rx_visible(rx_visible),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines),
    .timing_error(timing_error)
  );

  // ---------------------------------------------------------------------------
  // Transmitter model and event bookkeeping
  // ---------------------------------------------------------------------------
  int tx_col = 0;
  int tx_row = 0;
  int htot   = HT;
  int vtot   = VT;
  bit src_on  = 1'b0;
  bit h_force = 1'b0;
  bit h_pend  = 1'b0;
  bit v_pend  = 1'b0;
  bit h_edge  = 1'b0;   // DUT saw an hfall at the edge just taken
  bit v_edge  = 1'b0;   // DUT saw a vfall at the edge just taken
  int hcount  = 0;
  int vcount  = 0;
  int te_cnt  = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge, then the
  // transmitter takes its own edge (syncs registered from the old position).
  task automatic tick();
    logic hs_n, vs_n;
    @(posedge clock);
    h_edge = h_pend;
    v_edge = v_pend;
    #1;
    if (h_edge) hcount++;
    if (v_edge) vcount++;
    if (timing_error) te_cnt++;
    h_pend = 1'b0;
    v_pend = 1'b0;
    if (src_on) begin
      hs_n = h_force ? 1'b1 : !(tx_col >= HSTR && tx_col <= HSTR + 1);
      vs_n = !(tx_row >= VSTR && tx_row <= VSTR + 1);
      if (tx_col >= htot) begin
        tx_col = 0;
        tx_row = (tx_row >= vtot) ? 0 : tx_row + 1;
      end else begin
        tx_col = tx_col + 1;
      end
      h_pend = hsync && !hs_n;
      v_pend = vsync && !vs_n;
      hsync  = hs_n;
      vsync  = vs_n;
    end
  endtask

  task automatic run_to(input int row, input int col, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (tx_row == row && tx_col == col) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vfalls(input int n, input int limit, output bit ok);
    int target;
    target = vcount + n;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (vcount == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    bit lock_seen;
    bit found;

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    check("rst_col", rx_col, 0);
    check("rst_row", rx_row, 0);
    check("rst_line_len", line_len, 0);
    check("rst_frame_lines", frame_lines, 0);
    check("rst_locked", locked, 0);
    check("rst_terr", timing_error, 0);
    check("rst_visible", rx_visible, 0);

    // Ideal source from reset: track alignment until the second vfall.
    reset  = 1'b1;
    src_on = 1'b1;
    te_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      check("acq_col", rx_col, tx_col);
      check("acq_row", rx_row, tx_row);
      if (h_edge && hcount == 1) check("first_hfall_len", line_len, 0);
      if (h_edge && hcount == 2) check("second_hfall_len", line_len, HT + 1);
      if (v_edge && vcount == 1) check("first_vfall_frame", frame_lines, 0);
      if (v_edge && vcount == 2) check("second_vfall_frame", frame_lines, VT + 1);
      check("acq_locked", locked, (vcount >= 2) ? 1 : 0);
      if (vcount == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("acq_reached", ok, 1);
    check("acq_no_terr", te_cnt, 0);

    // One locked frame: column, row and visible flag follow the source.
    for (int i = 0; i < (HT + 1) * (VT + 1); i++) begin
      tick();
      check("lock_col", rx_col, tx_col);
      check("lock_row", rx_row, tx_row);
      check("lock_vis", rx_visible, (tx_col <= HF && tx_row <= VF) ? 1 : 0);
    end
    check("lock_held", locked, 1);
    check("lock_no_terr", te_cnt, 0);
    check("lock_line_len", line_len, HT + 1);

    // One line stretched by a cycle.
    run_to(2, 0, 1000, ok);
    check("stretch_reach", ok, 1);
    te_cnt = 0;
    htot = HT + 1;
    run_to(3, 0, 100, ok);
    htot = HT;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (timing_error) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("stretch_pulse_seen", found, 1);
    check("stretch_at_hfall", h_edge, 1);
    check("stretch_len", line_len, HT + 2);
    check("stretch_unlock", locked, 0);
    tick();
    check("stretch_pulse_one", timing_error, 0);
    run_vfalls(1, 1000, ok);
    check("stretch_vf1_unlocked", locked, 0);
    run_vfalls(1, 1000, ok);
    check("stretch_relock", locked, 1);
    check("stretch_single_pulse", te_cnt, 1);

    // hsync stuck high while locked: one timeout pulse, none after.
    te_cnt = 0;
    h_force = 1'b1;
    repeat (120) tick();
    check("timeout_pulses", te_cnt, 1);
    check("timeout_unlock", locked, 0);
    h_force = 1'b0;
    te_cnt = 0;
    run_vfalls(2, 2000, ok);
    check("timeout_relock_reach", ok, 1);
    check("timeout_relock", locked, 1);
    check("timeout_quiet_search", te_cnt, 0);

    // Frame one line long while locked.
    te_cnt = 0;
    vtot = VT + 1;
    run_vfalls(1, 1000, ok);
    vtot = VT;
    check("long_frame_reach", ok, 1);
    check("long_frame_terr", timing_error, 1);
    check("long_frame_lines", frame_lines, VT + 2);
    check("long_frame_unlock", locked, 0);
    tick();
    check("long_frame_pulse_one", timing_error, 0);

    // Relock, then reset mid-frame with syncs falling on the same edge.
    run_vfalls(2, 2000, ok);
    check("pre_reset_locked", locked, 1);
    repeat (100) tick();
    reset  = 1'b0;
    src_on = 1'b0;
    hsync  = 1'b0;
    vsync  = 1'b0;
    tick();
    check("mid_rst_col", rx_col, 0);
    check("mid_rst_row", rx_row, 0);
    check("mid_rst_line_len", line_len, 0);
    check("mid_rst_frame_lines", frame_lines, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_terr", timing_error, 0);
    check("mid_rst_visible", rx_visible, 0);
    tick();
    reset  = 1'b1;
    te_cnt = 0;
    repeat (5) tick();
    check("low_release_col", rx_col, 5);
    check("low_release_row", rx_row, 0);
    check("low_release_len", line_len, 0);
    check("low_release_locked", locked, 0);
    check("low_release_terr", te_cnt, 0);

    // Short lines from reset: never locks, never errors.
    reset = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    tx_col = 0;
    tx_row = 0;
    htot = HT - 1;
    vtot = VT;
    repeat (2) tick();
    reset  = 1'b1;
    src_on = 1'b1;
    te_cnt = 0;
    lock_seen = 1'b0;
    for (int i = 0; i < 3 * HT * (VT + 1) + 50; i++) begin
      tick();
      lock_seen |= locked;
    end
    check("short_never_locked", lock_seen, 0);
    check("short_no_terr", te_cnt, 0);
    check("short_line_len", line_len, HT);
    check("short_frame_lines", frame_lines, VT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
